// File: rtl/pc_unit.sv
// Program-counter unit: next-PC select, stall, halt/resume, misaligned-target trap with EPC.
// Define PC_RAS_EN to add a circular return-address stack for call/return redirects.
`timescale 1ns/1ps
module pc_unit #(
  parameter int unsigned      WIDTH       = 32,
  parameter int unsigned      INSTR_BYTES = 4,
  parameter logic [WIDTH-1:0] RESET_ADDR  = '0,
  parameter logic [WIDTH-1:0] EXC_VECTOR  = WIDTH'('h80),
  parameter int unsigned      RAS_DEPTH   = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             stall,
  input  logic             branch_taken,
  input  logic [WIDTH-1:0] branch_target,
  input  logic             jump,
  input  logic [WIDTH-1:0] jump_target,
  input  logic             jump_reg,
  input  logic [WIDTH-1:0] reg_target,
  input  logic             halt_req,
  input  logic             resume,
  input  logic             clear_err,
  input  logic             ras_call,
  input  logic             ras_ret,
  output logic [WIDTH-1:0] pc,
  output logic [WIDTH-1:0] pc_plus,
  output logic [WIDTH-1:0] epc,
  output logic             misalign_err,
  output logic             halted,
  output logic             ras_empty
);

  localparam logic [WIDTH-1:0] STEP       = WIDTH'(INSTR_BYTES);
  localparam logic [WIDTH-1:0] ALIGN_MASK = WIDTH'(INSTR_BYTES - 1);

  typedef enum logic {RUN, HALT} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] pc_q, pc_d;
  logic [WIDTH-1:0] epc_q, epc_d;
  logic             err_q, err_d;
  logic             run_ok;
  logic             redirect;
  logic [WIDTH-1:0] tgt;
  logic             misaligned;
  logic             ret_hit;
  logic [WIDTH-1:0] ras_top;

  assign pc_plus      = pc_q + STEP;
  assign pc           = pc_q;
  assign epc          = epc_q;
  assign misalign_err = err_q;
  assign halted       = (state_q == HALT);

  // Redirect priority: jump_reg > jump > branch; a live return takes the stack top.
  always_comb begin
    redirect = 1'b0;
    tgt      = '0;
    if (jump_reg) begin
      redirect = 1'b1;
      tgt      = ret_hit ? ras_top : reg_target;
    end else if (jump) begin
      redirect = 1'b1;
      tgt      = jump_target;
    end else if (branch_taken) begin
      redirect = 1'b1;
      tgt      = branch_target;
    end
  end

  assign misaligned = |(tgt & ALIGN_MASK);

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    epc_d   = epc_q;
    err_d   = err_q;
    run_ok  = 1'b0;
    if (!stall) begin
      if (clear_err) err_d = 1'b0;
      case (state_q)
        RUN: begin
          if (halt_req) begin
            state_d = HALT;
          end else begin
            run_ok = 1'b1;
            if (!redirect) begin
              pc_d = pc_plus;
            end else if (misaligned) begin
              // Trap overrides a same-cycle clear_err.
              pc_d  = EXC_VECTOR;
              epc_d = pc_q;
              err_d = 1'b1;
            end else begin
              pc_d = tgt;
            end
          end
        end
        HALT: if (resume) state_d = RUN;
        default: state_d = RUN;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= RUN;
      pc_q    <= RESET_ADDR;
      epc_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      epc_q   <= epc_d;
      err_q   <= err_d;
    end
  end

`ifdef PC_RAS_EN
  localparam int unsigned PW = (RAS_DEPTH > 1) ? $clog2(RAS_DEPTH) : 1;
  localparam int unsigned CW = $clog2(RAS_DEPTH + 1);

  logic [RAS_DEPTH-1:0][WIDTH-1:0] ras_mem;
  logic [PW-1:0]                   top_q, top_nxt, top_prv;
  logic [CW-1:0]                   cnt_q;
  logic                            do_push, do_pop;

  assign ras_empty = (cnt_q == '0);
  assign ras_top   = ras_mem[top_q];
  assign ret_hit   = ras_ret && !ras_empty;
  assign do_push   = run_ok && ras_call && (jump || jump_reg);
  assign do_pop    = run_ok && ras_ret && jump_reg && !ras_empty;

  // top_q indexes the newest entry; the ring wraps so a full push drops the oldest.
  assign top_nxt = (top_q == PW'(RAS_DEPTH - 1)) ? '0 : top_q + 1'b1;
  assign top_prv = (top_q == '0) ? PW'(RAS_DEPTH - 1) : top_q - 1'b1;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ras_mem <= '0;
      top_q   <= '0;
      cnt_q   <= '0;
    end else if (do_push && do_pop) begin
      ras_mem[top_q] <= pc_plus;
    end else if (do_push) begin
      ras_mem[top_nxt] <= pc_plus;
      top_q            <= top_nxt;
      if (cnt_q != CW'(RAS_DEPTH)) cnt_q <= cnt_q + 1'b1;
    end else if (do_pop) begin
      top_q <= top_prv;
      cnt_q <= cnt_q - 1'b1;
    end
  end
`else
  logic unused_ras;
  assign unused_ras = ras_call ^ ras_ret ^ run_ok;
  assign ras_empty  = 1'b1;
  assign ret_hit    = 1'b0;
  assign ras_top    = '0;
`endif

endmodule

// File: tb/tb_pc_unit.sv
// Self-checking bench for pc_unit: directed steps plus a randomized run against a queue-based model.
`timescale 1ns/1ps
module tb_pc_unit;
  localparam int DEPTH = 2;
`ifdef PC_RAS_EN
  localparam bit RAS = 1'b1;
`else
  localparam bit RAS = 1'b0;
`endif

  logic        clk = 1'b0, reset = 1'b0;
  logic        stall, branch_taken, jump, jump_reg, halt_req, resume, clear_err, ras_call, ras_ret;
  logic [31:0] branch_target, jump_target, reg_target;
  logic [31:0] pc, pc_plus, epc;
  logic        misalign_err, halted, ras_empty;

  logic       jump8 = 1'b0;
  logic [7:0] jt8 = 8'h0;
  logic [7:0] pc8, pp8, epc8;
  logic       err8, halted8, re8;

  always #5 clk = ~clk;

  pc_unit #(.WIDTH(32), .INSTR_BYTES(4), .RESET_ADDR(32'h0), .EXC_VECTOR(32'h80), .RAS_DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset), .stall(stall), .branch_taken(branch_taken), .branch_target(branch_target),
    .jump(jump), .jump_target(jump_target), .jump_reg(jump_reg), .reg_target(reg_target),
    .halt_req(halt_req), .resume(resume), .clear_err(clear_err), .ras_call(ras_call), .ras_ret(ras_ret),
    .pc(pc), .pc_plus(pc_plus), .epc(epc), .misalign_err(misalign_err), .halted(halted), .ras_empty(ras_empty));

  pc_unit #(.WIDTH(8), .EXC_VECTOR(8'h80)) u8 (
    .clk(clk), .reset(reset), .stall(1'b0), .branch_taken(1'b0), .branch_target(8'h0),
    .jump(jump8), .jump_target(jt8), .jump_reg(1'b0), .reg_target(8'h0),
    .halt_req(1'b0), .resume(1'b0), .clear_err(1'b0), .ras_call(1'b0), .ras_ret(1'b0),
    .pc(pc8), .pc_plus(pp8), .epc(epc8), .misalign_err(err8), .halted(halted8), .ras_empty(re8));

  int checks = 0, errors = 0;

  // Reference state: architectural values only; the stack is a queue with the newest at the back.
  logic [31:0] m_pc, m_epc, n_pc, n_epc;
  bit          m_err, m_halt, n_err, n_halt;
  logic [31:0] m_ras[$], n_ras[$];

  task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    m_pc = 32'h0; m_epc = 32'h0; m_err = 0; m_halt = 0; m_ras.delete();
  endtask

  task automatic model_next();
    logic [31:0] t;
    bit          redir;
    n_pc = m_pc; n_epc = m_epc; n_err = m_err; n_halt = m_halt; n_ras = m_ras;
    if (stall) return;
    if (clear_err) n_err = 0;
    if (m_halt) begin
      if (resume) n_halt = 0;
    end else if (halt_req) begin
      n_halt = 1;
    end else begin
      redir = 1; t = 32'h0;
      if (jump_reg) t = (RAS && ras_ret && m_ras.size() > 0) ? m_ras[$] : reg_target;
      else if (jump) t = jump_target;
      else if (branch_taken) t = branch_target;
      else redir = 0;
      if (RAS) begin
        if (ras_ret && jump_reg && m_ras.size() > 0) void'(n_ras.pop_back());
        if (ras_call && (jump || jump_reg)) begin
          n_ras.push_back(m_pc + 32'd4);
          if (n_ras.size() > DEPTH) void'(n_ras.pop_front());
        end
      end
      if (!redir) n_pc = m_pc + 32'd4;
      else if (t % 4 != 0) begin n_pc = 32'h80; n_epc = m_pc; n_err = 1; end
      else n_pc = t;
    end
  endtask

  task automatic check_all(string tag);
    check({tag, ".pc"}, pc, m_pc);
    check({tag, ".pc_plus"}, pc_plus, m_pc + 32'd4);
    check({tag, ".epc"}, epc, m_epc);
    check({tag, ".err"}, {31'b0, misalign_err}, {31'b0, m_err});
    check({tag, ".halted"}, {31'b0, halted}, {31'b0, m_halt});
    check({tag, ".ras_empty"}, {31'b0, ras_empty}, {31'b0, (RAS ? m_ras.size() == 0 : 1'b1)});
  endtask

  task automatic clear_inputs();
    stall = 0; branch_taken = 0; jump = 0; jump_reg = 0; halt_req = 0; resume = 0;
    clear_err = 0; ras_call = 0; ras_ret = 0;
    branch_target = 0; jump_target = 0; reg_target = 0;
  endtask

  task automatic step(string tag);
    model_next();
    @(posedge clk); #1;
    m_pc = n_pc; m_epc = n_epc; m_err = n_err; m_halt = n_halt; m_ras = n_ras;
    check_all(tag);
    clear_inputs();
  endtask

  task automatic go_to(logic [31:0] a);
    jump = 1; jump_target = a; step("goto");
  endtask

  initial begin
    clear_inputs();
    model_reset();
    #12 reset = 1;
    check_all("reset");
    check("reset.pc_const", pc, 32'h0);

    step("free"); check("free1", pc, 32'h4);
    step("free"); check("free2", pc, 32'h8);
    step("free"); check("free3", pc, 32'hC);
    #3 reset = 0;
    #1 model_reset();
    check("async_reset", pc, 32'h0);
    check_all("async_reset");
    #2 reset = 1;

    go_to(32'h10);
    branch_taken = 1; branch_target = 32'h40; jump = 1; jump_target = 32'h80;
    step("prio"); check("prio_jump", pc, 32'h80);
    stall = 1; branch_taken = 1; branch_target = 32'h40;
    step("stall"); check("stall_hold", pc, 32'h80);

    go_to(32'h20);
    jump_reg = 1; reg_target = 32'h33;
    step("trap");
    check("trap_pc", pc, 32'h80); check("trap_epc", epc, 32'h20); check("trap_err", {31'b0, misalign_err}, 32'h1);
    clear_err = 1;
    step("clr"); check("clr_err", {31'b0, misalign_err}, 32'h0);
    jump = 1; jump_target = 32'h42; clear_err = 1;
    step("trap_vs_clr"); check("trap_wins", {31'b0, misalign_err}, 32'h1);

    go_to(32'h8);
    halt_req = 1; step("halt");
    for (int i = 0; i < 5; i++) begin
      jump = 1; jump_target = 32'h40;
      step("halted"); check("halt_pc", pc, 32'h8); check("halt_flag", {31'b0, halted}, 32'h1);
    end
    resume = 1; step("resume"); check("resume_pc", pc, 32'h8);
    step("after_resume"); check("after_resume_pc", pc, 32'hC);

    jump8 = 1; jt8 = 8'hFC;
    step("w8a"); check("w8_fc", {24'b0, pc8}, 32'hFC); check("w8_plus", {24'b0, pp8}, 32'h0);
    jump8 = 0;
    step("w8b"); check("w8_wrap", {24'b0, pc8}, 32'h0);

`ifdef PC_RAS_EN
    go_to(32'h0);
    jump = 1; ras_call = 1; jump_target = 32'h10; step("call0");
    check("call0_ne", {31'b0, ras_empty}, 32'h0);
    jump = 1; ras_call = 1; jump_target = 32'h20; step("call1");
    jump = 1; ras_call = 1; jump_target = 32'h40; step("call2");
    jump_reg = 1; ras_ret = 1; reg_target = 32'h100; step("ret0"); check("ret0_pc", pc, 32'h24);
    jump_reg = 1; ras_ret = 1; reg_target = 32'h100; step("ret1"); check("ret1_pc", pc, 32'h14);
    jump_reg = 1; ras_ret = 1; reg_target = 32'h100; step("ret2"); check("ret2_pc", pc, 32'h100);
    check("ret2_empty", {31'b0, ras_empty}, 32'h1);
`endif

    for (int i = 0; i < 400; i++) begin
      stall         = ($urandom_range(7) == 0);
      halt_req      = ($urandom_range(15) == 0);
      resume        = ($urandom_range(3) == 0);
      clear_err     = ($urandom_range(7) == 0);
      branch_taken  = ($urandom_range(4) == 0);
      jump          = ($urandom_range(5) == 0);
      jump_reg      = ($urandom_range(5) == 0);
      ras_call      = ($urandom_range(3) == 0);
      ras_ret       = ($urandom_range(3) == 0);
      branch_target = $urandom & ((($urandom_range(7) == 0)) ? 32'hFFFF_FFFF : 32'hFFFF_FFFC);
      jump_target   = $urandom & ((($urandom_range(7) == 0)) ? 32'hFFFF_FFFF : 32'hFFFF_FFFC);
      reg_target    = $urandom & ((($urandom_range(7) == 0)) ? 32'hFFFF_FFFF : 32'hFFFF_FFFC);
      step("rand");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/pc_unit.md
Name: pc_unit

Overview:
- Parametrised program-counter unit for the MIPS core; replaces the plain PC register.
- Holds the fetch address and selects the next PC internally: sequential, branch, jump or jump-register.
- Adds stall, halt/resume, misaligned-target trapping with an EPC capture, and an optional return-address stack.
- Sits between control/branch logic and instruction memory.

Parameters:
- WIDTH, 32, address width in bits.
- INSTR_BYTES, 4, instruction size in bytes; power of two, at least 1; also the alignment unit.
- RESET_ADDR, 0, PC value on reset; must be aligned.
- EXC_VECTOR, 'h80, PC loaded on a misaligned target; must be aligned.
- RAS_DEPTH, 4, return-stack entries, at least 2; used only with PC_RAS_EN.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- stall  in  1  hold all state this cycle.
- branch_taken  in  1  take branch_target.
- branch_target  in  WIDTH  branch destination.
- jump  in  1  take jump_target.
- jump_target  in  WIDTH  jump destination.
- jump_reg  in  1  take reg_target (or the RAS top on a return).
- reg_target  in  WIDTH  register-sourced destination.
- halt_req  in  1  enter HALT.
- resume  in  1  leave HALT.
- clear_err  in  1  clear misalign_err.
- ras_call  in  1  push pc_plus (valid with jump or jump_reg).
- ras_ret  in  1  pop the RAS for this jump_reg.
- pc  out  WIDTH  current fetch address.
- pc_plus  out  WIDTH  pc + INSTR_BYTES, combinational.
- epc  out  WIDTH  pc of the instruction whose redirect trapped.
- misalign_err  out  1  sticky trap flag.
- halted  out  1  high in the HALT state.
- ras_empty  out  1  RAS holds no entries.

Behaviour:
- Reset (reset=0, asynchronous):
  - pc=RESET_ADDR, epc=0, misalign_err=0.
  - State RUN, halted=0.
  - RAS count=0, ras_empty=1.
- Arithmetic:
  - pc_plus = (pc + INSTR_BYTES) mod 2^WIDTH; the wrap from all-ones back to low addresses is silent.
  - Every update takes effect one cycle after the inputs are sampled.
- States: RUN and HALT.
- stall=1, in either state: no register changes; all other inputs are ignored.
- RUN with stall=0, priority from highest to lowest:
  1. halt_req: pc holds, go to HALT; any redirect or RAS operation that cycle is dropped.
  2. jump_reg: target = reg_target, or the RAS top when ras_ret=1 (see feature).
  3. jump: target = jump_target.
  4. branch_taken: target = branch_target.
  5. Otherwise: pc <= pc_plus.
- Misalignment applies to a selected redirect target:
  - The target is misaligned when its low log2(INSTR_BYTES) bits are non-zero.
  - A misaligned target gives pc <= EXC_VECTOR, epc <= pc, misalign_err <= 1.
  - An aligned target gives pc <= target.
- misalign_err is cleared only by clear_err=1 with stall=0, or by reset.
  - A new trap in the same cycle as clear_err wins: the flag stays 1.
- HALT:
  - pc holds, halted=1; redirects and halt_req are ignored.
  - resume=1 with stall=0: go to RUN; pc advances from the next cycle.
  - resume in RUN is ignored.
- Reset asserted mid-operation, including during HALT, returns everything immediately to the reset values.

Optional Feature:
- Macro: PC_RAS_EN.
- Defined: a RAS_DEPTH-entry return-address stack. It operates only in RUN with stall=0 and halt_req=0.
  - ras_call with jump or jump_reg pushes pc_plus.
  - When full, a push overwrites the oldest entry (circular); the count saturates at RAS_DEPTH.
  - ras_ret with jump_reg and a non-empty stack: target = top, then pop.
  - ras_ret on an empty stack: falls back to reg_target; the count stays 0.
  - ras_call and ras_ret in the same cycle: the target is the old top, and pc_plus replaces the top (count unchanged).
  - ras_call or ras_ret without the required jump qualifier is ignored.
- Undefined: no stack storage; ras_call and ras_ret are ignored, ras_empty is tied to 1, and jump_reg always uses reg_target.

Test Plan:
- Reset then 3 free-running cycles (defaults): pc = 0, 4, 8, C.
  - Assert reset mid-count: pc = 0 at once, asynchronously.
- pc = 'h10; branch_taken with 'h40 and jump with 'h80 in the same cycle:
  - Next pc = 'h80.
  - Next cycle, stall=1 with branch_taken: pc stays 'h80.
- pc = 'h20; jump_reg with reg_target 'h33:
  - pc = 'h80 (EXC_VECTOR), epc = 'h20, misalign_err = 1.
  - clear_err then drops the flag to 0.
- halt_req at pc = 'h8:
  - halted = 1 and pc stays 'h8 for 5 cycles, with jump pulses ignored.
  - resume: pc = 'h8 next, then 'hC.
- WIDTH=8 with pc = 'hFC: next pc = 'h00 (wrap).
- PC_RAS_EN, RAS_DEPTH=2: calls from 'h0, 'h10 and 'h20 (pushes 4, 14, 24), then three returns:
  - Targets 24, 14, then reg_target with ras_empty = 1.
  - 4 is overwritten by the third call.
